// File: rtl/pet_scan_doubler.sv
// pet_scan_doubler: ping-pong line buffer that replays each captured scanline twice at clk16 rate
module pet_scan_doubler #(
    parameter int BUF_DEPTH        = 512,
    parameter int LEN_W            = 11,
    parameter int DEFAULT_LINE_LEN = 1024,
    parameter int MIN_LINE_LEN     = 64,
    parameter int OUT_HSYNC_LEN    = 48
) (
    input  logic clk16_i,
    input  logic reset_n_i,
    input  logic pixel_en_i,
    input  logic h_sync_i,
    input  logic v_sync_i,
    input  logic video_i,
    output logic h_sync_o,
    output logic v_sync_o,
    output logic video_o,
    output logic line_valid_o
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [LEN_W-1:0] DEPTH   = LEN_W'(BUF_DEPTH);
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_LINE_LEN);
    localparam logic [LEN_W-1:0] HS_LEN  = LEN_W'(OUT_HSYNC_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'(DEFAULT_LINE_LEN);

    logic mem [2][BUF_DEPTH];
    logic hs_q, wr_bank, seen_start, start, wb, we, rd;
    logic [LEN_W-1:0] wr_addr, out_x, line_len, cnt, half, wa;

    // a line start redirects this cycle's pixel to address 0 of the fresh bank
    assign start = h_sync_i & ~hs_q;
    assign wb    = start ? ~wr_bank : wr_bank;
    assign wa    = start ? '0 : wr_addr;
    assign we    = pixel_en_i & (wa < DEPTH);
    assign half  = line_len >> 1;
    assign rd    = (out_x < DEPTH) ? mem[~wr_bank][out_x[AW-1:0]] : 1'b0;

    always_ff @(posedge clk16_i)
        if (we) mem[wb][wa[AW-1:0]] <= video_i;

    always_ff @(posedge clk16_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hs_q         <= 1'b0;
            wr_bank      <= 1'b0;
            wr_addr      <= '0;
            out_x        <= '0;
            line_len     <= DEF_LEN;
            cnt          <= '0;
            seen_start   <= 1'b0;
            line_valid_o <= 1'b0;
            video_o      <= 1'b0;
            h_sync_o     <= 1'b0;
            v_sync_o     <= 1'b0;
        end else begin
            hs_q         <= h_sync_i;
            wr_bank      <= wb;
            wr_addr      <= wa + LEN_W'(we);
            cnt          <= start ? LEN_W'(1) : cnt + LEN_W'(~&cnt);
            if (start && cnt >= MIN_LEN) line_len <= cnt;
            out_x        <= (start || out_x == half - 1'b1) ? '0 : out_x + 1'b1;
            seen_start   <= seen_start | start;
            line_valid_o <= line_valid_o | (start & seen_start);
            video_o      <= rd & line_valid_o;
            h_sync_o     <= out_x < HS_LEN;
            v_sync_o     <= (out_x == '0) ? v_sync_i : v_sync_o;
        end
    end
endmodule

// File: tb/tb_pet_scan_doubler.sv
// tb_pet_scan_doubler: directed line sequences with hand-derived replay timing for pet_scan_doubler
module tb_pet_scan_doubler;
    logic clk16_i = 0, reset_n_i = 0, pixel_en_i = 0, h_sync_i = 0, v_sync_i = 0, video_i = 0;
    logic h_sync_o, v_sync_o, video_o, line_valid_o;
    int checks = 0, errors = 0, line_no = 0, kk = 0, starts = 0;
    logic vs_exp = 0, valid_exp = 0;

    pet_scan_doubler dut (
        .clk16_i(clk16_i), .reset_n_i(reset_n_i), .pixel_en_i(pixel_en_i),
        .h_sync_i(h_sync_i), .v_sync_i(v_sync_i), .video_i(video_i),
        .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .video_o(video_o),
        .line_valid_o(line_valid_o)
    );

    always #5 clk16_i = ~clk16_i;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s line %0d k %0d: got %b want %b", tag, line_no, kk, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk16_i);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hs"}, h_sync_o, 1'b0);
        chk({tag, "_vs"}, v_sync_o, 1'b0);
        chk({tag, "_vid"}, video_o, 1'b0);
        chk({tag, "_valid"}, line_valid_o, 1'b0);
    endtask

    // free-running output straight after reset: 48-cycle pulse every 512 cycles
    task automatic idle(input int n);
        for (int e = 1; e <= n; e++) begin
            tick();
            kk = e;
            chk("idle_hs", h_sync_o, ((e - 1) % 512) < 48);
            chk("idle_vid", video_o, 1'b0);
            chk("idle_vs", v_sync_o, 1'b0);
            chk("idle_valid", line_valid_o, 1'b0);
        end
    endtask

    // mode 0: pixel every 2nd cycle, ones at p<8; mode 1: pixel every cycle, ones at p<8 and 520..527; mode 2: zeros
    // after edge k>=1 the outputs show out_x = (k-1) % half; replay shows ones for lo <= x < hi
    task automatic run_line(input int len, input int mode, input bit hs_en, input int half,
                            input int lo, input int hi, input int vs_from, input int vs_to);
        line_no++;
        if (hs_en) begin
            starts++;
            valid_exp = starts >= 2;
        end
        for (int k = 0; k < len; k++) begin
            int p, x;
            logic vin;
            p = (mode == 1) ? k : k / 2;
            vin = k >= vs_from && k < vs_to;
            h_sync_i = hs_en && k < 4;
            pixel_en_i = (mode == 1) || (k % 2 == 0);
            video_i = (mode == 0 && p < 8) || (mode == 1 && (p < 8 || (p >= 520 && p < 528)));
            v_sync_i = vin;
            tick();
            kk = k;
            if (k > 0) begin
                x = (k - 1) % half;
                if (x == 0) vs_exp = vin;
                chk("hs", h_sync_o, x < 48);
                chk("vid", video_o, valid_exp && x >= lo && x < hi);
                chk("vs", v_sync_o, vs_exp);
                chk("valid", line_valid_o, valid_exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            h_sync_i = 1'($urandom);
            v_sync_i = 1'($urandom);
            pixel_en_i = 1'($urandom);
            video_i = 1'($urandom);
            tick();
            kk = i;
            chk_zero("rst");
        end
        h_sync_i = 0;
        v_sync_i = 0;
        pixel_en_i = 0;
        video_i = 0;
        reset_n_i = 1;
        idle(1024);
        for (int i = 0; i < 4; i++) run_line(1024, 0, 1, 512, 0, 8, 0, 0);
        run_line(1024, 1, 1, 512, 0, 8, 0, 0);
        run_line(1024, 1, 1, 512, 0, 8, 0, 0);
        run_line(300, 0, 1, 512, 0, 8, 0, 0);
        run_line(1024, 0, 1, 150, 0, 8, 0, 0);
        run_line(1024, 0, 1, 512, 0, 8, 0, 0);
        run_line(10, 2, 1, 512, 0, 8, 0, 0);
        run_line(1024, 0, 1, 512, 5, 8, 0, 0);
        run_line(1024, 0, 1, 512, 0, 8, 700, 1024);
        run_line(1024, 0, 1, 512, 0, 8, 0, 300);
        run_line(1024, 0, 1, 512, 0, 8, 0, 0);
        run_line(2048, 2, 0, 512, 0, 8, 0, 0);
        h_sync_i = 0;
        v_sync_i = 0;
        pixel_en_i = 0;
        video_i = 0;
        reset_n_i = 0;
        #1;
        kk = -1;
        chk_zero("async_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            kk = i;
            chk_zero("mid_rst");
        end
        reset_n_i = 1;
        idle(100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
